// File: rtl/mac_pkg.sv
// Shared types and default sizes for the multiply-and-accumulate block.
package mac_pkg;

   // Default operand and accumulator widths.
   localparam int DEF_IN_W  = 5;
   localparam int DEF_ACC_W = 16;

   // Control sequence: sample operands, iterate shift-add, fold into accumulator.
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      MULT  = 2'd1,
      ACC   = 2'd2
   } mac_state_t;

endpackage

// File: rtl/mac_shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per step.
// load captures the operands and arms the counter; step performs one
// iteration; done is high while the final iteration is being performed.
module mac_shift_add_mul
   import mac_pkg::*;
#(
   parameter int IN_W = DEF_IN_W
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              load,
   input  logic              step,
   input  logic [IN_W-1:0]   multiplicand,
   input  logic [IN_W-1:0]   multiplier,
   output logic [2*IN_W-1:0] product,
   output logic              done
);

   localparam int CNT_W = $clog2(IN_W + 1);

   logic [2*IN_W-1:0] mcand_q;
   logic [IN_W-1:0]   mplier_q;
   logic [2*IN_W-1:0] prod_q;
   logic [CNT_W-1:0]  cnt_q;

   // Operand, product and iteration registers; load wins over step.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
      end else if (load) begin
         mcand_q  <= {{IN_W{1'b0}}, multiplicand};
         mplier_q <= multiplier;
         prod_q   <= '0;
         cnt_q    <= CNT_W'(IN_W);
      end else if (step) begin
         if (mplier_q[0])
            prod_q <= prod_q + mcand_q;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q - CNT_W'(1);
      end
   end

   // The step taken while the counter reads 1 is the last one.
   assign done    = (cnt_q == CNT_W'(1));
   assign product = prod_q;

endmodule

// File: rtl/mul_and_acc.sv
// Multiply-and-accumulate: FETCH -> MULT (IN_W cycles) -> ACC -> FETCH.
// Each operation takes IN_W+2 cycles; the result register updates on the
// ACC cycle's edge. Define MAC_SATURATE_EN to clamp the accumulator at its
// maximum value instead of wrapping.
module mul_and_acc
   import mac_pkg::*;
#(
   parameter int IN_W  = DEF_IN_W,
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic             mac_clk_i,
   input  logic             mac_nreset_i,
   input  logic [IN_W-1:0]  mac_multiplicand_i,
   input  logic [IN_W-1:0]  mac_multiplier_i,
   output logic [ACC_W-1:0] mac_result_o,
   output logic             updating_acc_result_o,
   output logic             fetching_input_o
);

   mac_state_t        state_q, state_d;
   logic              load, step, done;
   logic [2*IN_W-1:0] product;
   logic [ACC_W-1:0]  acc_q, acc_next;

   mac_shift_add_mul #(.IN_W(IN_W)) u_mul (
      .clk          (mac_clk_i),
      .nreset       (mac_nreset_i),
      .load         (load),
      .step         (step),
      .multiplicand (mac_multiplicand_i),
      .multiplier   (mac_multiplier_i),
      .product      (product),
      .done         (done)
   );

   // State register.
   always_ff @(posedge mac_clk_i) begin
      if (!mac_nreset_i)
         state_q <= FETCH;
      else
         state_q <= state_d;
   end

   // Next state and strobes, decoded from the state register only.
   always_comb begin
      state_d               = state_q;
      load                  = 1'b0;
      step                  = 1'b0;
      fetching_input_o      = 1'b0;
      updating_acc_result_o = 1'b0;
      case (state_q)
         FETCH: begin
            fetching_input_o = 1'b1;
            load             = 1'b1;
            state_d          = MULT;
         end
         MULT: begin
            step = 1'b1;
            if (done)
               state_d = ACC;
         end
         ACC: begin
            updating_acc_result_o = 1'b1;
            state_d               = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

`ifdef MAC_SATURATE_EN
   // Widen the sum so overflow is visible, then clamp at all-ones.
   localparam int SUM_W = ((ACC_W > 2*IN_W) ? ACC_W : 2*IN_W) + 1;
   logic [SUM_W-1:0] sum;
   assign sum      = SUM_W'(acc_q) + SUM_W'(product);
   assign acc_next = (sum > SUM_W'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
   // Plain modular accumulate.
   assign acc_next = acc_q + ACC_W'(product);
`endif

   // Accumulator: written only on the ACC cycle.
   always_ff @(posedge mac_clk_i) begin
      if (!mac_nreset_i)
         acc_q <= '0;
      else if (state_q == ACC)
         acc_q <= acc_next;
   end

   assign mac_result_o = acc_q;

endmodule

// File: tb/tb_mul_and_acc.sv
// Bench for mul_and_acc: directed operations, a cycle-phase reference model
// checked every cycle, and hand-computed literal expectations.
module tb_mul_and_acc;

   localparam int IN_W  = 5;
   localparam int ACC_W = 16;
   localparam int OP_CYC = IN_W + 2;

   logic             clk = 1'b0;
   logic             nreset = 1'b0;
   logic [IN_W-1:0]  mcand = '0;
   logic [IN_W-1:0]  mplier = '0;
   logic [ACC_W-1:0] result;
   logic             upd, fetch;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mul_and_acc #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
      .mac_clk_i             (clk),
      .mac_nreset_i          (nreset),
      .mac_multiplicand_i    (mcand),
      .mac_multiplier_i      (mplier),
      .mac_result_o          (result),
      .updating_acc_result_o (upd),
      .fetching_input_o      (fetch)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint acc_add(input longint a, input longint p);
      longint s;
      s = a + p;
`ifdef MAC_SATURATE_EN
      if (s > (longint'(1) << ACC_W) - 1) s = (longint'(1) << ACC_W) - 1;
`else
      s = s % (longint'(1) << ACC_W);
`endif
      return s;
   endfunction

   // Reference model: one operation every OP_CYC cycles from reset; operands
   // taken on the edge ending the first cycle, their product added on the
   // edge ending the last one.
   bit     m_valid = 0;
   int     m_phase = 0;
   longint m_acc = 0, m_a = 0, m_b = 0;

   always @(posedge clk) begin
      if (!nreset) begin
         m_valid = 1;
         m_phase = 0;
         m_acc   = 0;
      end else if (m_valid) begin
         if (m_phase == 0) begin
            m_a = longint'(mcand);
            m_b = longint'(mplier);
         end
         if (m_phase == OP_CYC - 1)
            m_acc = acc_add(m_acc, m_a * m_b);
         m_phase = (m_phase + 1) % OP_CYC;
      end
   end

   // Per-cycle compare against the model.
   always @(posedge clk) begin
      #2;
      if (m_valid) begin
         chk("model_fetch", fetch, (m_phase == 0));
         chk("model_update", upd, (m_phase == OP_CYC - 1));
         chk("model_result", result, m_acc);
      end
   end

   // Entered at a negedge inside a FETCH cycle; returns at the negedge of the
   // next FETCH cycle with the cycle spacing and the offset of the ACC pulse.
   task automatic run_op(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                         input bit toggle, output int spacing, output int upd_at);
      int g = 0;
      while (fetch !== 1'b1 && g < 20) begin
         @(negedge clk);
         g++;
      end
      chk("wait_fetch", fetch, 1);
      mcand   = a;
      mplier  = b;
      spacing = 0;
      upd_at  = 0;
      do begin
         @(negedge clk);
         spacing++;
         if (upd === 1'b1 && upd_at == 0) upd_at = spacing;
         if (toggle && fetch !== 1'b1) begin
            mcand  = IN_W'($urandom);
            mplier = IN_W'($urandom);
         end
      end while (fetch !== 1'b1 && spacing < 20);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      nreset = 1'b0;
      mcand  = '0;
      mplier = '0;
      @(negedge clk);
      nreset = 1'b1;
   endtask

   initial begin
      int sp, ua, cnt;
      logic [ACC_W-1:0] sat_exp;

      repeat (2) @(negedge clk);
      nreset = 1'b1;
      chk("reset_result", result, 0);
      chk("reset_fetch", fetch, 1);
      chk("reset_update", upd, 0);

      run_op(5'd3, 5'd5, 0, sp, ua);
      chk("op3x5_result", result, 15);
      chk("op3x5_upd_at", ua, 6);
      chk("op3x5_spacing", sp, 7);

      run_op(5'd31, 5'd31, 0, sp, ua);
      chk("op31x31_result", result, 976);
      chk("op31x31_spacing", sp, 7);

      run_op(5'd0, 5'd17, 0, sp, ua);
      chk("zero_result", result, 976);
      chk("zero_upd_at", ua, 6);

      run_op(5'd7, 5'd9, 1, sp, ua);
      chk("toggle_result", result, 1039);

      // Reset two cycles into MULT with the accumulator holding 15.
      pulse_reset();
      run_op(5'd3, 5'd5, 0, sp, ua);
      chk("pre_abort_result", result, 15);
      mcand  = 5'd10;
      mplier = 5'd10;
      repeat (2) @(negedge clk);
      mcand  = '0;
      mplier = '0;
      nreset = 1'b0;
      @(negedge clk);
      nreset = 1'b1;
      chk("abort_result", result, 0);
      chk("abort_fetch", fetch, 1);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (upd === 1'b1) cnt++;
      end
      chk("abort_no_update", cnt, 0);

      // Long run of maximal products to cross the accumulator range.
      pulse_reset();
      for (int i = 0; i < 69; i++)
         run_op(5'd31, 5'd31, 0, sp, ua);
`ifdef MAC_SATURATE_EN
      sat_exp = 16'd65535;
`else
      sat_exp = 16'd773;
`endif
      chk("overflow_result", result, sat_exp);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mul_and_acc.md
MUL_AND_ACC -- requirements
Module: MulAndAcc

Interface
REQ-001 Parameter IN_W, default 5, operand width in bits.
REQ-002 Parameter ACC_W, default 16, accumulator and result width in bits.
REQ-003 mac_clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 mac_nreset_i  input  1  reset; synchronous and active-low (sampled on the rising edge of mac_clk_i).
REQ-005 mac_multiplicand_i  input  IN_W  unsigned multiplicand.
REQ-006 mac_multiplier_i  input  IN_W  unsigned multiplier.
REQ-007 mac_result_o  output  ACC_W  registered accumulator value.
REQ-008 updating_acc_result_o  output  1  high during the cycle in which the accumulator is written.
REQ-009 fetching_input_o  output  1  high during the cycle in which operands are sampled.

Function
REQ-010 The block SHALL implement a 3-state FSM: FETCH -> MULT -> ACC -> FETCH.
- Outputs are decoded from the state register only.
REQ-011 In FETCH, the block SHALL assert fetching_input_o.
- On the next rising edge it latches both operands, clears the 2*IN_W-bit product register, loads the iteration counter with IN_W, and enters MULT.
REQ-012 In MULT, the block SHALL perform one unsigned shift-add step per cycle:
- If multiplier LSB is 1, add the shifted multiplicand to the product.
- Shift the multiplicand left and the multiplier right by 1.
- Decrement the counter.
REQ-013 The block SHALL leave MULT for ACC after exactly IN_W cycles (5 at default).
REQ-014 In ACC, the block SHALL assert updating_acc_result_o for exactly one cycle.
- On that cycle's rising edge, the accumulator takes accumulator + zero-extended product, and the FSM enters FETCH.
REQ-015 One operation SHALL take IN_W+2 cycles (7 at default).
- Operand sampling recurs every 7 cycles.
- The new mac_result_o is visible in the cycle following the ACC cycle, which is also the next FETCH cycle.
REQ-016 Operand inputs SHALL be ignored outside FETCH; changes during MULT/ACC have no effect.
REQ-017 Without the saturation feature, accumulation SHALL wrap modulo 2^ACC_W.
REQ-018 fetching_input_o and updating_acc_result_o SHALL never be high in the same cycle.
REQ-019 Zero operands SHALL still run the full IN_W+2 sequence, including the ACC pulse, leaving the accumulator unchanged.

Reset
REQ-020 While mac_nreset_i is low at a rising edge, the block SHALL set state=FETCH, accumulator=0, product=0, operand registers=0, and counter=0.
REQ-021 After reset, mac_result_o SHALL read 0 and fetching_input_o SHALL be 1 from the cycle following the reset edge.
REQ-022 Reset asserted mid-MULT or mid-ACC SHALL abort the operation without updating the accumulator.

Configuration
REQ-023 With macro MAC_SATURATE_EN defined, accumulation SHALL clamp at 2^ACC_W-1 instead of wrapping.
- Once saturated, the accumulator holds that value until reset.
REQ-024 Without MAC_SATURATE_EN, the block SHALL wrap per REQ-017 and contain no saturation logic.

Structure
REQ-025 A shared package mac_pkg SHALL hold:
- the FSM state enum typedef (FETCH, MULT, ACC);
- default IN_W/ACC_W constants.
REQ-026 The shift-add datapath SHALL be a sub-module mac_shift_add_mul (operand, product and counter registers, plus a done flag).
- The top level holds the FSM and the accumulator.

Verification
REQ-027 Reset, then 3 x 5 -> fetching_input_o high 1 cycle; updating_acc_result_o pulses 6 cycles later; mac_result_o = 15 on the next cycle.
REQ-028 After REQ-027, 31 x 31 -> mac_result_o = 976; spacing between fetching_input_o pulses = 7 cycles.
REQ-029 69 consecutive 31 x 31 from reset -> mac_result_o = 773 (wrap).
- With MAC_SATURATE_EN, the same stimulus -> 65535.
REQ-030 0 x 17 -> updating_acc_result_o still pulses; mac_result_o unchanged.
REQ-031 Operand inputs toggled every cycle during MULT -> product uses only the values sampled in FETCH.
REQ-032 mac_nreset_i low for one edge during MULT (accumulator = 15) -> mac_result_o = 0, state FETCH next cycle, no ACC pulse.
